mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, memory address width.
REQ-002 Parameter: DATA_W, 32, memory data width.
REQ-003 Parameter: CLR_DEPTH, 65536, number of words zeroed by a clear sequence (1..2^ADDR_W).
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: req0, req1  input  1 each  access request from requester 0/1.
REQ-007 Port: we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 Port: addr0, addr1  input  ADDR_W each  request address.
REQ-009 Port: wdata0, wdata1  input  DATA_W each  write data.
REQ-010 Port: gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-011 Port: rvalid0, rvalid1  output  1 each  read data valid.
REQ-012 Port: rdata0, rdata1  output  DATA_W each  read data.
REQ-013 Port: clr_start  input  1  one-cycle request to zero words 0..CLR_DEPTH-1.
REQ-014 Port: clr_busy  output  1  clear sequence in progress.
REQ-015 Port: clr_done  output  1  one-cycle pulse when clear completes.
REQ-016 Port: mem_addr  output  ADDR_W  memory address.
REQ-017 Port: mem_we  output  1  memory write enable.
REQ-018 Port: mem_wdata  output  DATA_W  memory write data.
REQ-019 Port: mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.

Function
REQ-020 States: IDLE, CLEAR; reset state IDLE.
REQ-021 IDLE: at most one gnt per cycle; gnt is combinational from req and priority pointer.
REQ-022 Round-robin: pointer selects preferred requester; sole requester always wins; both requesting -> pointer's requester wins.
REQ-023 Pointer update: on any grant, pointer moves to the non-granted requester; no grant -> pointer unchanged; reset value 0.
REQ-024 Grant cycle: mem_addr/mem_we/mem_wdata driven combinationally from granted requester; write takes effect at the ending clock edge.
REQ-025 No grant in IDLE: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-026 Read latency 1: granted read captures mem_rdata into rdataN at the ending edge; rvalidN = 1 for exactly the next cycle.
REQ-027 rdataN holds its value until the next read grant to N; writes never assert rvalid.
REQ-028 Handshake: requester holds req/we/addr/wdata stable until gnt; deasserting req before gnt drops the request with no memory effect.
REQ-029 Back-to-back: a requester holding req continuously may be granted in consecutive cycles only when the other is idle; otherwise grants alternate.
REQ-030 IDLE with clr_start = 1: normal arbitration still occurs that cycle; next state CLEAR with counter = 0.
REQ-031 CLEAR: each cycle mem_we = 1, mem_wdata = 0, mem_addr = counter; counter increments by 1 (ADDR_W+1 bits, no wrap before CLR_DEPTH).
REQ-032 CLEAR: gnt0 = gnt1 = 0; requests stall; pointer unchanged; clr_busy = 1.
REQ-033 CLEAR exit: in the cycle counter = CLR_DEPTH-1 the last write is issued; next cycle state IDLE and clr_done = 1 for one cycle.
REQ-034 clr_start during CLEAR is ignored; clr_start on the clr_done cycle starts a new clear next cycle.
REQ-035 Clear takes exactly CLR_DEPTH cycles from first to last write.

Reset
REQ-036 rst low asynchronously forces IDLE, pointer = 0, counter = 0, rvalid0/1 = 0, rdata0/1 = 0, clr_busy = 0, clr_done = 0, mem_we = 0.
REQ-037 Reset mid-CLEAR abandons the sequence; no clr_done; already-written words stay zero.
REQ-038 Reset release: first grant possible in first cycle with rst high.

Verification
REQ-039 req0 write addr 0x0010 data 0xDEADBEEF, then req0 read 0x0010 -> gnt0 each cycle; rvalid0 = 1 with rdata0 = 0xDEADBEEF one cycle after read grant.
REQ-040 req0 and req1 both held for 4 cycles from reset -> grants 0,1,0,1; only one gnt high per cycle.
REQ-041 CLR_DEPTH = 8, words 0..9 preloaded 0xFFFFFFFF, pulse clr_start -> clr_busy 8 cycles, mem_we with addresses 0..7, clr_done pulse; word 7 reads 0, word 8 reads 0xFFFFFFFF.
REQ-042 req1 held during clear -> gnt1 = 0 throughout clr_busy; gnt1 = 1 on clr_done cycle.
REQ-043 rst low at clear cycle 3 (CLR_DEPTH = 8) -> clr_busy = 0 immediately; no clr_done; words 0..2 zero, 3..7 unchanged.
REQ-044 clr_start with req0 read same IDLE cycle -> gnt0 that cycle, rvalid0 next cycle, clear begins next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with a built-in clear sequencer.
// In IDLE one requester at a time is granted combinational access to a
// single-port memory; in CLEAR the block sweeps addresses 0..CLR_DEPTH-1
// writing zeros while all requests stall.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int CLR_DEPTH = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter value of the final clear write; the counter is one bit wider
    // than the address so CLR_DEPTH = 2^ADDR_W is representable without wrap.
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(CLR_DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;        // 0 prefers requester 0, 1 prefers requester 1
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt0_c, gnt1_c;

    // Arbitration, memory bus steering and clear sequencing.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                // Grants are suppressed while reset is asserted so a held
                // write request cannot reach the memory during reset.
                if (rst) begin
                    if (req0 && (!req1 || !ptr_q)) begin
                        gnt0_c = 1'b1;
                    end else if (req1) begin
                        gnt1_c = 1'b1;
                    end
                end
                if (gnt0_c) begin
                    mem_addr  = addr0;
                    mem_we    = we0;
                    mem_wdata = wdata0;
                    ptr_d     = 1'b1;
                end else if (gnt1_c) begin
                    mem_addr  = addr1;
                    mem_we    = we1;
                    mem_wdata = wdata1;
                    ptr_d     = 1'b0;
                end
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                mem_addr  = cnt_q[ADDR_W-1:0];
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CLR_LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read return path: capture memory data on a granted read.
    always_comb begin
        rvalid0_d = gnt0_c && !we0;
        rvalid1_d = gnt1_c && !we1;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    // Control state: FSM, round-robin pointer, clear counter, done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Read data registers and their one-cycle valid flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign gnt0     = gnt0_c;
    assign gnt1     = gnt1_c;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, read
// data, clear writes and done pulses; a negedge monitor pops and compares.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          clr_start = 1'b0;
    logic          clr_busy, clr_done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_DEPTH(CD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, clocked write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gx_t;

    gx_t           exp_g[$];
    logic [DW-1:0] exp_rd0[$];
    logic [DW-1:0] exp_rd1[$];
    logic [AW-1:0] exp_clr[$];
    int            exp_done[$];
    int            n_vec = 0;
    int            n_bad = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void unexp(string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: actual=event required=none", nm);
    endfunction

    // Monitor: compare every DUT output event against the scoreboard.
    always @(negedge clk) begin
        gx_t g;
        if (gnt0 || gnt1) begin
            chk("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
            if (exp_g.size() == 0) unexp("gnt_unexpected");
            else begin
                g = exp_g.pop_front();
                chk("gnt_id", gnt1 ? 64'd1 : 64'd0, 64'(g.id));
                chk("bus_we", {63'd0, mem_we}, {63'd0, g.we});
                chk("bus_addr", 64'(mem_addr), 64'(g.addr));
                chk("bus_wdata", 64'(mem_wdata), 64'(g.data));
            end
        end else if (!clr_busy) begin
            chk("idle_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
        end
        if (rvalid0) begin
            if (exp_rd0.size() == 0) unexp("rvalid0_unexpected");
            else chk("rdata0", 64'(rdata0), 64'(exp_rd0.pop_front()));
        end
        if (rvalid1) begin
            if (exp_rd1.size() == 0) unexp("rvalid1_unexpected");
            else chk("rdata1", 64'(rdata1), 64'(exp_rd1.pop_front()));
        end
        if (clr_busy) begin
            chk("clr_we", {63'd0, mem_we}, 64'd1);
            chk("clr_wdata", 64'(mem_wdata), 64'd0);
            if (exp_clr.size() == 0) unexp("clr_write_unexpected");
            else chk("clr_addr", 64'(mem_addr), 64'(exp_clr.pop_front()));
        end
        if (clr_done) begin
            if (exp_done.size() == 0) unexp("clr_done_unexpected");
            else void'(exp_done.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(int id, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic push_g(int id, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        gx_t g;
        g.id = id; g.we = w; g.addr = a; g.data = d;
        exp_g.push_back(g);
    endtask

    // One transaction; entered and left just after a rising edge.
    task automatic xfer(int id, bit w, logic [AW-1:0] a, logic [DW-1:0] d,
                        logic [DW-1:0] rexp, output int waited);
        bit got = 1'b0;
        push_g(id, w, a, d);
        if (!w) begin
            if (id == 0) exp_rd0.push_back(rexp);
            else         exp_rd1.push_back(rexp);
        end
        drive(id, 1'b1, w, a, d);
        waited = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = (id == 0) ? gnt0 : gnt1;
            if (!got) waited++;
        end
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
        chk("rst_rdata0", 64'(rdata0), 64'd0);
        chk("rst_rdata1", 64'(rdata1), 64'd0);
        chk("rst_clr", {62'd0, clr_busy, clr_done}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Wait for clr_done, counting busy cycles; pulses clr_start mid-clear.
    task automatic wait_done(output int busy, output bit seen);
        busy = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (clr_done) seen = 1'b1;
            else if (clr_busy) begin
                busy++;
                chk("clr_gnt_stall", {62'd0, gnt0, gnt1}, 64'd0);
                if (busy == 3) clr_start = 1'b1;
                if (busy == 4) clr_start = 1'b0;
            end
        end
        if (!seen) chk("clr_done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int w;
        int busy;
        bit seen;

        // Reset with a write request already pending.
        drive(0, 1'b1, 1'b1, 16'h0005, 32'h0000_0055);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
        chk("rst_mem_we_held_req", {63'd0, mem_we}, 64'd0);
        chk("rst_rdata0", 64'(rdata0), 64'd0);
        chk("rst_clr", {62'd0, clr_busy, clr_done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        xfer(0, 1'b1, 16'h0005, 32'h0000_0055, '0, w);
        chk("first_gnt_latency", 64'(w), 64'd0);

        // Write then read back from requester 0 in consecutive cycles.
        xfer(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, '0, w);
        xfer(0, 1'b0, 16'h0010, '0, 32'hDEAD_BEEF, w);
        chk("b2b_latency", 64'(w), 64'd0);
        xfer(0, 1'b1, 16'h0011, 32'h0000_1234, '0, w);
        repeat (2) @(negedge clk);
        chk("rvalid0_after_write", {63'd0, rvalid0}, 64'd0);
        chk("rdata0_hold", 64'(rdata0), 64'hDEAD_BEEF);
        @(posedge clk); #1;

        // Both requesters held from reset: grants alternate 0,1,0,1.
        do_reset();
        push_g(0, 1'b1, 16'h0020, 32'h0000_00A0);
        push_g(1, 1'b1, 16'h0021, 32'h0000_00B1);
        push_g(0, 1'b1, 16'h0020, 32'h0000_00A0);
        push_g(1, 1'b1, 16'h0021, 32'h0000_00B1);
        drive(0, 1'b1, 1'b1, 16'h0020, 32'h0000_00A0);
        drive(1, 1'b1, 1'b1, 16'h0021, 32'h0000_00B1);
        repeat (4) @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Cross reads, both requesting; pointer favours requester 0.
        push_g(0, 1'b0, 16'h0021, '0); exp_rd0.push_back(32'h0000_00B1);
        push_g(1, 1'b0, 16'h0020, '0); exp_rd1.push_back(32'h0000_00A0);
        drive(0, 1'b1, 1'b0, 16'h0021, '0);
        drive(1, 1'b1, 1'b0, 16'h0020, '0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0);

        // Requester 1 withdraws before being granted: no memory effect.
        push_g(0, 1'b1, 16'h0030, 32'h0000_0011);
        drive(0, 1'b1, 1'b1, 16'h0030, 32'h0000_0011);
        drive(1, 1'b1, 1'b1, 16'h0030, 32'h0000_0022);
        @(negedge clk);
        chk("gnt1_held_off", {63'd0, gnt1}, 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        xfer(1, 1'b0, 16'h0030, '0, 32'h0000_0011, w);

        // Clear sequence with a read in the same IDLE cycle as clr_start.
        for (int a = 0; a < 10; a++) xfer(0, 1'b1, AW'(a), 32'hFFFF_FFFF, '0, w);
        push_g(0, 1'b0, 16'h0009, '0); exp_rd0.push_back(32'hFFFF_FFFF);
        for (int a = 0; a < CD; a++) exp_clr.push_back(AW'(a));
        exp_done.push_back(1);
        push_g(1, 1'b0, 16'h0007, '0); exp_rd1.push_back(32'h0000_0000);
        drive(0, 1'b1, 1'b0, 16'h0009, '0);
        clr_start = 1'b1;
        @(negedge clk);
        chk("clr_busy_start_cycle", {63'd0, clr_busy}, 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        clr_start = 1'b0;
        drive(1, 1'b1, 1'b0, 16'h0007, '0);
        wait_done(busy, seen);
        chk("clr_busy_cycles", 64'(busy), 64'(CD));
        chk("gnt1_on_done", {63'd0, gnt1}, 64'd1);

        // clr_start on the done cycle launches another clear.
        for (int a = 0; a < CD; a++) exp_clr.push_back(AW'(a));
        exp_done.push_back(1);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        drive(1, 1'b0, 1'b0, '0, '0);
        wait_done(busy, seen);
        chk("clr2_busy_cycles", 64'(busy), 64'(CD));
        @(posedge clk); #1;
        xfer(0, 1'b0, 16'h0008, '0, 32'hFFFF_FFFF, w);
        xfer(0, 1'b0, 16'h0007, '0, 32'h0000_0000, w);

        // Reset during clear cycle 3 abandons the sequence.
        for (int a = 0; a < CD; a++) xfer(1, 1'b1, AW'(a), 32'hFFFF_FFFF, '0, w);
        for (int a = 0; a < 4; a++) exp_clr.push_back(AW'(a));
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_clr_busy", {63'd0, clr_busy}, 64'd0);
        chk("rst_mid_clr_we", {63'd0, mem_we}, 64'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        for (int a = 0; a < CD; a++)
            xfer(0, 1'b0, AW'(a), '0, (a < 3) ? 32'h0 : 32'hFFFF_FFFF, w);

        repeat (4) @(posedge clk);
        chk("sb_gnt_empty", 64'(exp_g.size()), 64'd0);
        chk("sb_rd0_empty", 64'(exp_rd0.size()), 64'd0);
        chk("sb_rd1_empty", 64'(exp_rd1.size()), 64'd0);
        chk("sb_clr_empty", 64'(exp_clr.size()), 64'd0);
        chk("sb_done_empty", 64'(exp_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
